// File: rtl/drum_audio_streamer_if.sv
// Memory-mapped bus between the drum audio streamer and the audio codec core.
// The streamer is the single master of this bus.
//   bus_address     master -> slave  32  word address
//   bus_read        master -> slave   1  read request
//   bus_write       master -> slave   1  write request
//   bus_writedata   master -> slave  32  write data
//   bus_readdata    slave -> master  32  read data, valid while waitrequest is low
//   bus_waitrequest slave -> master   1  stall; request is held while high
interface drum_audio_streamer_if;
    logic [31:0] bus_address;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_writedata;
    logic [31:0] bus_readdata;
    logic        bus_waitrequest;

    modport master (
        output bus_address,
        output bus_read,
        output bus_write,
        output bus_writedata,
        input  bus_readdata,
        input  bus_waitrequest
    );

    modport slave (
        input  bus_address,
        input  bus_read,
        input  bus_write,
        input  bus_writedata,
        output bus_readdata,
        output bus_waitrequest
    );
endinterface

// File: rtl/drum_audio_streamer.sv
// Takes the drum grid's center-node amplitude once per time step and writes it to the audio
// core as a left/right sample pair. One sample is held at a time; samples arriving while a
// transfer is in flight are dropped and counted so the grid is never stalled.
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   sample_valid   one-cycle pulse per grid time step
//   sample         signed 1.17 amplitude
//   sample_ready   holding register empty
//   bus            master side of the audio core bus (registered outputs)
//   busy           transfer FSM not idle
//   overrun_count  saturating count of dropped samples
module drum_audio_streamer #(
    parameter logic [31:0] FIFOSPACE_ADDR = 32'h0000_3044,
    parameter logic [31:0] LEFT_ADDR      = 32'h0000_3048,
    parameter logic [31:0] RIGHT_ADDR     = 32'h0000_304C,
    parameter int unsigned SHIFT          = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [17:0]           sample,
    output logic                  sample_ready,
    drum_audio_streamer_if.master bus,
    output logic                  busy,
    output logic [15:0]           overrun_count
);

    typedef enum logic [2:0] {
        StIdle,
        StRdSpace,
        StChkSpace,
        StWrLeft,
        StWrRight
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic        r_full;
    logic [17:0] r_hold;
    logic [15:0] r_space;
    logic [15:0] w_space_next;
    logic [15:0] r_overrun;

    logic        r_read;
    logic        r_write;
    logic [31:0] r_address;
    logic [31:0] r_writedata;
    logic        w_read_next;
    logic        w_write_next;
    logic [31:0] w_address_next;
    logic [31:0] w_writedata_next;

    logic        w_accept;
    logic        w_drop;
    logic        w_done;
    logic        w_space_ok;
    logic [31:0] w_sext;
    logic [31:0] w_pcm;
    logic        w_unused;

    assign w_accept = sample_valid & ~r_full;
    assign w_drop   = sample_valid & r_full;
    assign w_done   = (r_state == StWrRight) & ~bus.bus_waitrequest;

    // Captured fifospace[31:16]: WSLC in [15:8], WSRC in [7:0].
    assign w_space_ok = (r_space[15:8] != 8'd0) && (r_space[7:0] != 8'd0);

    assign w_sext = {{14{r_hold[17]}}, r_hold};
    assign w_pcm  = w_sext << SHIFT;

    // Low half of fifospace carries read-side counts, which playback does not need.
    assign w_unused = ^bus.bus_readdata[15:0];

    always_comb begin
        w_state_next = r_state;
        w_space_next = r_space;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = StRdSpace;
                end
            end
            StRdSpace: begin
                if (!bus.bus_waitrequest) begin
                    w_space_next = bus.bus_readdata[31:16];
                    w_state_next = StChkSpace;
                end
            end
            StChkSpace: begin
                w_state_next = w_space_ok ? StWrLeft : StRdSpace;
            end
            StWrLeft: begin
                if (!bus.bus_waitrequest) begin
                    w_state_next = StWrRight;
                end
            end
            StWrRight: begin
                if (!bus.bus_waitrequest) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase

        // Bus outputs are decoded from the next state so they appear registered in the
        // same cycle the state becomes active, and hold while waitrequest keeps the state.
        w_read_next      = 1'b0;
        w_write_next     = 1'b0;
        w_address_next   = 32'd0;
        w_writedata_next = 32'd0;
        case (w_state_next)
            StRdSpace: begin
                w_read_next    = 1'b1;
                w_address_next = FIFOSPACE_ADDR;
            end
            StWrLeft: begin
                w_write_next     = 1'b1;
                w_address_next   = LEFT_ADDR;
                w_writedata_next = w_pcm;
            end
            StWrRight: begin
                w_write_next     = 1'b1;
                w_address_next   = RIGHT_ADDR;
                w_writedata_next = w_pcm;
            end
            default: begin
                w_read_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_full      <= 1'b0;
            r_hold      <= 18'd0;
            r_space     <= 16'd0;
            r_overrun   <= 16'd0;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_address   <= 32'd0;
            r_writedata <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_space     <= w_space_next;
            r_read      <= w_read_next;
            r_write     <= w_write_next;
            r_address   <= w_address_next;
            r_writedata <= w_writedata_next;
            if (w_accept) begin
                r_hold <= sample;
                r_full <= 1'b1;
            end else if (w_done) begin
                r_full <= 1'b0;
            end
            if (w_drop && (r_overrun != 16'hFFFF)) begin
                r_overrun <= r_overrun + 16'd1;
            end
        end
    end

    assign sample_ready      = ~r_full;
    assign busy              = (r_state != StIdle);
    assign overrun_count     = r_overrun;
    assign bus.bus_read      = r_read;
    assign bus.bus_write     = r_write;
    assign bus.bus_address   = r_address;
    assign bus.bus_writedata = r_writedata;

endmodule

// File: tb/tb_drum_audio_streamer.sv
// Directed bench for drum_audio_streamer: two instances share the sample input, one with
// SHIFT=14 driven by a scripted bus slave, one with SHIFT=0 on an always-ready slave.
module tb_drum_audio_streamer;
    localparam logic [31:0] FIFO_A  = 32'h0000_3044;
    localparam logic [31:0] LEFT_A  = 32'h0000_3048;
    localparam logic [31:0] RIGHT_A = 32'h0000_304C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [17:0] sample = 18'd0;
    logic        ready0, busy0, ready1, busy1;
    logic [15:0] ovr0, ovr1;
    int          checks = 0;
    int          failures = 0;

    drum_audio_streamer_if bus0();
    drum_audio_streamer_if bus1();

    always #5 clk = ~clk;

    drum_audio_streamer #(.SHIFT(14)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_ready (ready0),
        .bus          (bus0.master),
        .busy         (busy0),
        .overrun_count(ovr0)
    );

    drum_audio_streamer #(.SHIFT(0)) dut1 (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_ready (ready1),
        .bus          (bus1.master),
        .busy         (busy1),
        .overrun_count(ovr1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (ready0 !== 1'b1) begin
            failures++; $display("FAIL reset_ready: got %b want 1", ready0);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            failures++; $display("FAIL reset_busy: got %b want 0", busy0);
        end
        checks++;
        if ({bus0.bus_read, bus0.bus_write} !== 2'b00) begin
            failures++; $display("FAIL reset_strobes: got %b%b want 00", bus0.bus_read,
                                 bus0.bus_write);
        end
        checks++;
        if ({bus0.bus_address, bus0.bus_writedata} !== 64'd0) begin
            failures++; $display("FAIL reset_addr_data: got %h/%h want 0/0", bus0.bus_address,
                                 bus0.bus_writedata);
        end
        checks++;
        if (ovr0 !== 16'd0) begin
            failures++; $display("FAIL reset_overrun: got %h want 0", ovr0);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Single transfer on both instances; also covers the SHIFT=0 data path.
    task automatic test_single(input logic [17:0] s, input logic [31:0] d0,
                               input logic [31:0] d1, input string tag);
        bus0.bus_readdata    = 32'h8080_0000;
        bus0.bus_waitrequest = 1'b0;
        sample       = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            logic        e_rd, e_wr;
            logic [31:0] e_addr;
            e_rd   = (k == 1);
            e_wr   = (k == 3) || (k == 4);
            e_addr = (k == 1) ? FIFO_A : (k == 3) ? LEFT_A : RIGHT_A;
            checks++;
            if ({bus0.bus_read, bus0.bus_write} !== {e_rd, e_wr}) begin
                failures++; $display("FAIL %s_strobes c%0d: got %b%b want %b%b", tag, k,
                                     bus0.bus_read, bus0.bus_write, e_rd, e_wr);
            end
            if (e_rd || e_wr) begin
                checks++;
                if (bus0.bus_address !== e_addr) begin
                    failures++; $display("FAIL %s_addr c%0d: got %h want %h", tag, k,
                                         bus0.bus_address, e_addr);
                end
            end
            checks++;
            if (bus0.bus_writedata !== (e_wr ? d0 : 32'd0)) begin
                failures++; $display("FAIL %s_data14 c%0d: got %h want %h", tag, k,
                                     bus0.bus_writedata, e_wr ? d0 : 32'd0);
            end
            checks++;
            if (bus1.bus_writedata !== (e_wr ? d1 : 32'd0)) begin
                failures++; $display("FAIL %s_data0 c%0d: got %h want %h", tag, k,
                                     bus1.bus_writedata, e_wr ? d1 : 32'd0);
            end
            checks++;
            if ({busy0, ready0} !== {(k <= 4), (k == 5)}) begin
                failures++; $display("FAIL %s_busy_ready c%0d: got %b%b want %b%b", tag, k,
                                     busy0, ready0, (k <= 4), (k == 5));
            end
            tick();
        end
    endtask

    task automatic test_fifo_full();
        int          reads, reads_at_wr, lefts, rights, left_c, right_c, idle_c;
        logic [31:0] left_d;
        reads = 0; reads_at_wr = -1; lefts = 0; rights = 0;
        left_c = -1; right_c = -1; idle_c = -1; left_d = 32'd0;
        bus0.bus_readdata    = 32'h0080_0000;
        bus0.bus_waitrequest = 1'b0;
        sample       = 18'h00100;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (bus0.bus_read) begin
                reads++;
                bus0.bus_readdata = (reads <= 3) ? 32'h0080_0000 : 32'h0101_0000;
            end
            if (bus0.bus_write && reads_at_wr < 0) reads_at_wr = reads;
            if (bus0.bus_write && bus0.bus_address == LEFT_A) begin
                lefts++; left_c = k; left_d = bus0.bus_writedata;
            end
            if (bus0.bus_write && bus0.bus_address == RIGHT_A) begin
                rights++; right_c = k;
            end
            if (!busy0 && idle_c < 0) idle_c = k;
            checks++;
            if (bus0.bus_read && bus0.bus_write) begin
                failures++; $display("FAIL full_rd_wr_overlap c%0d: got 11 want not both", k);
            end
            tick();
        end
        checks++;
        if (reads != 4) begin
            failures++; $display("FAIL full_reads: got %0d want 4", reads);
        end
        checks++;
        if (reads_at_wr != 4) begin
            failures++; $display("FAIL full_reads_before_write: got %0d want 4", reads_at_wr);
        end
        checks++;
        if ({lefts, rights} !== {32'd1, 32'd1}) begin
            failures++; $display("FAIL full_write_counts: got %0d/%0d want 1/1", lefts, rights);
        end
        checks++;
        if ({left_c, right_c, idle_c} !== {32'd9, 32'd10, 32'd11}) begin
            failures++; $display("FAIL full_timing: got L%0d R%0d I%0d want L9 R10 I11", left_c,
                                 right_c, idle_c);
        end
        checks++;
        if (left_d !== 32'h0040_0000) begin
            failures++; $display("FAIL full_data: got %h want 00400000", left_d);
        end
    endtask

    task automatic test_waitrequest();
        bus0.bus_readdata    = 32'h8080_0000;
        bus0.bus_waitrequest = 1'b0;
        sample       = 18'h12345;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            logic        e_rd, e_wr;
            logic [31:0] e_addr;
            bus0.bus_waitrequest = (k <= 3) || (k >= 6 && k <= 8) || (k >= 10 && k <= 12);
            e_rd   = (k <= 4);
            e_wr   = (k >= 6) && (k <= 13);
            e_addr = (k <= 4) ? FIFO_A : (k <= 9) ? LEFT_A : RIGHT_A;
            checks++;
            if ({bus0.bus_read, bus0.bus_write} !== {e_rd, e_wr}) begin
                failures++; $display("FAIL wait_strobes c%0d: got %b%b want %b%b", k,
                                     bus0.bus_read, bus0.bus_write, e_rd, e_wr);
            end
            if (e_rd || e_wr) begin
                checks++;
                if (bus0.bus_address !== e_addr) begin
                    failures++; $display("FAIL wait_addr c%0d: got %h want %h", k,
                                         bus0.bus_address, e_addr);
                end
            end
            checks++;
            if (bus0.bus_writedata !== (e_wr ? 32'h48D1_4000 : 32'd0)) begin
                failures++; $display("FAIL wait_data c%0d: got %h want %h", k,
                                     bus0.bus_writedata, e_wr ? 32'h48D1_4000 : 32'd0);
            end
            checks++;
            if (busy0 !== (k <= 13)) begin
                failures++; $display("FAIL wait_busy c%0d: got %b want %b", k, busy0, (k <= 13));
            end
            tick();
        end
        bus0.bus_waitrequest = 1'b0;
    endtask

    task automatic test_overrun();
        bus0.bus_readdata    = 32'h8080_0000;
        bus0.bus_waitrequest = 1'b0;
        sample       = 18'h2AAAA;
        sample_valid = 1'b1;
        tick();
        sample = 18'h15555;
        for (int k = 1; k <= 7; k++) begin
            bus0.bus_waitrequest = (k <= 2);
            sample_valid         = (k <= 5);
            if (k == 5 || k == 6) begin
                checks++;
                if (bus0.bus_writedata !== 32'hAAAA_8000) begin
                    failures++; $display("FAIL ovr_data1 c%0d: got %h want aaaa8000", k,
                                         bus0.bus_writedata);
                end
            end
            if (k == 7) begin
                checks++;
                if (ovr0 !== 16'd5) begin
                    failures++; $display("FAIL ovr_count5: got %0d want 5", ovr0);
                end
            end
            tick();
        end
        // Second transfer stuck in the fifospace poll while the grid keeps pulsing.
        sample               = 18'h2AAAA;
        sample_valid         = 1'b1;
        bus0.bus_waitrequest = 1'b1;
        tick();
        sample = 18'h15555;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (i == 1000) begin
                checks++;
                if (ovr0 !== 16'd1005) begin
                    failures++; $display("FAIL ovr_count1005: got %0d want 1005", ovr0);
                end
            end
            if (i == 65529) begin
                checks++;
                if (ovr0 !== 16'hFFFE) begin
                    failures++; $display("FAIL ovr_count_fffe: got %h want fffe", ovr0);
                end
            end
        end
        checks++;
        if (ovr0 !== 16'hFFFF) begin
            failures++; $display("FAIL ovr_saturate: got %h want ffff", ovr0);
        end
        checks++;
        if ({bus0.bus_read, bus0.bus_address} !== {1'b1, FIFO_A}) begin
            failures++; $display("FAIL ovr_read_held: got %b/%h want 1/%h", bus0.bus_read,
                                 bus0.bus_address, FIFO_A);
        end
        sample_valid         = 1'b0;
        bus0.bus_waitrequest = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 3 || k == 4) begin
                checks++;
                if ({bus0.bus_write, bus0.bus_writedata} !== {1'b1, 32'hAAAA_8000}) begin
                    failures++; $display("FAIL ovr_data2 c%0d: got %b/%h want 1/aaaa8000", k,
                                         bus0.bus_write, bus0.bus_writedata);
                end
            end
            if (k == 5) begin
                checks++;
                if ({busy0, ovr0} !== {1'b0, 16'hFFFF}) begin
                    failures++; $display("FAIL ovr_end: got busy %b cnt %h want 0 ffff", busy0,
                                         ovr0);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_write();
        bus0.bus_readdata    = 32'h8080_0000;
        bus0.bus_waitrequest = 1'b0;
        sample       = 18'h00001;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus0.bus_write, bus0.bus_address} !== {1'b1, LEFT_A}) begin
            failures++; $display("FAIL rst_pre_wrleft: got %b/%h want 1/%h", bus0.bus_write,
                                 bus0.bus_address, LEFT_A);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus0.bus_write, busy0, ready0} !== 3'b001) begin
            failures++; $display("FAIL rst_mid_ctrl: got wr%b busy%b rdy%b want 0 0 1",
                                 bus0.bus_write, busy0, ready0);
        end
        checks++;
        if ({ovr0, bus0.bus_address, bus0.bus_writedata} !== 80'd0) begin
            failures++; $display("FAIL rst_mid_regs: got %h/%h/%h want 0/0/0", ovr0,
                                 bus0.bus_address, bus0.bus_writedata);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus0.bus_readdata    = 32'h8080_0000;
        bus0.bus_waitrequest = 1'b0;
        sample       = 18'h00010;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 3) begin
                checks++;
                if (bus0.bus_writedata !== 32'h0004_0000) begin
                    failures++; $display("FAIL b2b_dataA: got %h want 00040000",
                                         bus0.bus_writedata);
                end
            end
            if (k == 4) begin
                sample       = 18'h3FFFE;
                sample_valid = 1'b1;
            end
            tick();
        end
        checks++;
        if ({ovr0, ready0, busy0} !== {16'd1, 1'b1, 1'b0}) begin
            failures++; $display("FAIL b2b_last_cycle_drop: got cnt %0d rdy %b busy %b want 1 1 0",
                                 ovr0, ready0, busy0);
        end
        sample       = 18'h20000;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            logic        e_wr;
            logic [31:0] e_addr;
            e_wr   = (k == 3) || (k == 4);
            e_addr = (k == 1) ? FIFO_A : (k == 3) ? LEFT_A : RIGHT_A;
            checks++;
            if ({bus0.bus_read, bus0.bus_write} !== {(k == 1), e_wr}) begin
                failures++; $display("FAIL b2b_strobes c%0d: got %b%b want %b%b", k,
                                     bus0.bus_read, bus0.bus_write, (k == 1), e_wr);
            end
            if (k != 2 && k != 5) begin
                checks++;
                if (bus0.bus_address !== e_addr) begin
                    failures++; $display("FAIL b2b_addr c%0d: got %h want %h", k,
                                         bus0.bus_address, e_addr);
                end
            end
            checks++;
            if (bus0.bus_writedata !== (e_wr ? 32'h8000_0000 : 32'd0)) begin
                failures++; $display("FAIL b2b_dataC c%0d: got %h want %h", k,
                                     bus0.bus_writedata, e_wr ? 32'h8000_0000 : 32'd0);
            end
            tick();
        end
        checks++;
        if (ovr0 !== 16'd1) begin
            failures++; $display("FAIL b2b_count_end: got %0d want 1", ovr0);
        end
    endtask

    initial begin
        bus0.bus_readdata    = 32'h8080_0000;
        bus0.bus_waitrequest = 1'b0;
        bus1.bus_readdata    = 32'h8080_0000;
        bus1.bus_waitrequest = 1'b0;
        test_reset();
        test_single(18'h10000, 32'h4000_0000, 32'h0001_0000, "single");
        test_single(18'h3FFFF, 32'hFFFF_C000, 32'hFFFF_FFFF, "negative");
        test_fifo_full();
        test_waitrequest();
        test_overrun();
        test_reset_mid_write();
        test_single(18'h00001, 32'h0000_4000, 32'h0000_0001, "after_reset");
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
